// File: rtl/sw_debounce_pulse.sv
// Switch front-end: 2-flop synchroniser, per-channel qualify FSM, edge pulses.
// Optional FALL pulse output enabled by defining SW_DEBOUNCE_FALL_PULSE_EN.
module sw_debounce_pulse #(
    parameter int N_SW            = 4,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic [N_SW-1:0] SW,
    output logic [N_SW-1:0] DB,
    output logic [N_SW-1:0] RISE
`ifdef SW_DEBOUNCE_FALL_PULSE_EN
    ,
    output logic [N_SW-1:0] FALL
`endif
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // Bit 1 of the encoding is the accepted level, so DB is a state bit.
    typedef enum logic [1:0] {
        ST_LO = 2'b00,
        WT_HI = 2'b01,
        ST_HI = 2'b10,
        WT_LO = 2'b11
    } state_e;

    logic [N_SW-1:0] s1_q;
    logic [N_SW-1:0] s2_q;

    // Two-stage synchroniser for the raw switch levels.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= SW;
            s2_q <= s1_q;
        end
    end

    for (genvar g = 0; g < N_SW; g++) begin : g_ch
        state_e           state_q;
        state_e           state_d;
        logic [CNT_W-1:0] cnt_q;
        logic [CNT_W-1:0] cnt_d;
        logic             rise_q;
        logic             rise_d;
        logic             in_s;
        logic             qual;

        assign in_s = s2_q[g];
        assign qual = (cnt_q == CNT_MAX);

`ifdef SW_DEBOUNCE_FALL_PULSE_EN
        logic fall_q;
        logic fall_d;

        // Registered falling-edge pulse.
        always_ff @(posedge CLK or posedge RST) begin
            if (RST) begin
                fall_q <= 1'b0;
            end else begin
                fall_q <= fall_d;
            end
        end

        // Fall pulse fires on the cycle WT_LO qualifies.
        always_comb begin
            fall_d = (state_q == WT_LO) && !in_s && qual;
        end

        assign FALL[g] = fall_q;
`endif

        // State, qualify counter and rise pulse registers.
        always_ff @(posedge CLK or posedge RST) begin
            if (RST) begin
                state_q <= ST_LO;
                cnt_q   <= '0;
                rise_q  <= 1'b0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                rise_q  <= rise_d;
            end
        end

        // Next state and counter: any sample of the old level restarts.
        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            unique case (state_q)
                ST_LO: begin
                    if (in_s) begin
                        state_d = WT_HI;
                        cnt_d   = CNT_ONE;
                    end else begin
                        cnt_d = '0;
                    end
                end
                WT_HI: begin
                    if (!in_s) begin
                        state_d = ST_LO;
                        cnt_d   = '0;
                    end else if (qual) begin
                        state_d = ST_HI;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                ST_HI: begin
                    if (!in_s) begin
                        state_d = WT_LO;
                        cnt_d   = CNT_ONE;
                    end else begin
                        cnt_d = '0;
                    end
                end
                WT_LO: begin
                    if (in_s) begin
                        state_d = ST_HI;
                        cnt_d   = '0;
                    end else if (qual) begin
                        state_d = ST_LO;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
            endcase
        end

        // Rise pulse fires on the cycle WT_HI qualifies.
        always_comb begin
            rise_d = (state_q == WT_HI) && in_s && qual;
        end

        assign DB[g]   = state_q[1];
        assign RISE[g] = rise_q;
    end

endmodule

// File: tb/tb_sw_debounce_pulse.sv
// Directed bench for sw_debounce_pulse with N_SW=4, DEBOUNCE_CYCLES=4.
// Checks FALL too when SW_DEBOUNCE_FALL_PULSE_EN is defined.
module tb_sw_debounce_pulse;

    logic       CLK;
    logic       RST;
    logic [3:0] SW;
    logic [3:0] DB;
    logic [3:0] RISE;
`ifdef SW_DEBOUNCE_FALL_PULSE_EN
    logic [3:0] FALL;
`endif

    int tests = 0;
    int fails = 0;

    sw_debounce_pulse #(
        .N_SW(4),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .SW  (SW),
        .DB  (DB),
        .RISE(RISE)
`ifdef SW_DEBOUNCE_FALL_PULSE_EN
        ,
        .FALL(FALL)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [3:0] obs,
                         input logic [3:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        logic [5:0] bounce;
        logic [3:0] edb;
        logic [3:0] erise;
        bounce = 6'b101101;

        // 1: async reset with SW high, then fresh qualification
        RST = 1'b0;
        SW  = 4'h0;
        #2;
        RST = 1'b1;
        SW  = 4'hF;
        #1;
        check("t1_async_db", DB, 4'h0);
        check("t1_async_rise", RISE, 4'h0);
        repeat (3) tick();
        check("t1_hold_db", DB, 4'h0);
        RST = 1'b0;
        for (int e = 0; e < 8; e++) begin
            tick();
            check($sformatf("t1_db_e%0d", e), DB, (e >= 6) ? 4'hF : 4'h0);
            check($sformatf("t1_rise_e%0d", e), RISE, (e == 6) ? 4'hF : 4'h0);
        end

        // 5: all channels fall
        SW = 4'h0;
        for (int e = 0; e < 8; e++) begin
            tick();
            check($sformatf("t5_db_e%0d", e), DB, (e >= 6) ? 4'h0 : 4'hF);
            check($sformatf("t5_rise_e%0d", e), RISE, 4'h0);
`ifdef SW_DEBOUNCE_FALL_PULSE_EN
            check($sformatf("t5_fall_e%0d", e), FALL, (e == 6) ? 4'hF : 4'h0);
`endif
        end

        // 2: single channel rise
        SW = 4'h1;
        for (int e = 0; e < 8; e++) begin
            tick();
            check($sformatf("t2_db_e%0d", e), DB, (e >= 6) ? 4'h1 : 4'h0);
            check($sformatf("t2_rise_e%0d", e), RISE, (e == 6) ? 4'h1 : 4'h0);
        end

        // 3: bounce on channel 0
        SW = 4'h0;
        repeat (8) tick();
        check("t3_pre_db", DB, 4'h0);
        for (int e = 0; e < 13; e++) begin
            SW = (e <= 5) ? {3'b000, bounce[e]} : 4'h1;
            tick();
            check($sformatf("t3_db_e%0d", e), DB, (e >= 11) ? 4'h1 : 4'h0);
            check($sformatf("t3_rise_e%0d", e), RISE, (e == 11) ? 4'h1 : 4'h0);
        end

        // 4: channels 1,2 together, channel 3 two cycles later
        for (int e = 0; e < 10; e++) begin
            SW = (e >= 2) ? 4'hF : 4'h7;
            tick();
            if (e < 6) edb = 4'h1;
            else if (e < 8) edb = 4'h7;
            else edb = 4'hF;
            if (e == 6) erise = 4'h6;
            else if (e == 8) erise = 4'h8;
            else erise = 4'h0;
            check($sformatf("t4_db_e%0d", e), DB, edb);
            check($sformatf("t4_rise_e%0d", e), RISE, erise);
        end

        // 6: reset mid-qualify on channel 0
        SW = 4'h0;
        repeat (8) tick();
        check("t6_pre_db", DB, 4'h0);
        SW = 4'h1;
        for (int e = 0; e < 5; e++) begin
            tick();
            check($sformatf("t6_wait_db_e%0d", e), DB, 4'h0);
            check($sformatf("t6_wait_rise_e%0d", e), RISE, 4'h0);
        end
        RST = 1'b1;
        #1;
        check("t6_rst_db", DB, 4'h0);
        check("t6_rst_rise", RISE, 4'h0);
        tick();
        check("t6_rst_edge_rise", RISE, 4'h0);
        RST = 1'b0;
        for (int e = 0; e < 8; e++) begin
            tick();
            check($sformatf("t6_db_e%0d", e), DB, (e >= 6) ? 4'h1 : 4'h0);
            check($sformatf("t6_rise_e%0d", e), RISE, (e == 6) ? 4'h1 : 4'h0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
